qtpa_scalar_exec: RTL and testbench

- Scalar/control execute stage directly downstream of instruction issue.
- Consumes one 32-bit SI/SR/C-type instruction per cycle via valid/ready.
- Owns the 16x32 scalar register file (S0 zero, S13 tile size, S14 scale, S15 status), hardware loop counter, branch/loop redirect and HALT/YIELD control.

---
 rtl/qtpa_scalar_exec.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_qtpa_scalar_exec.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qtpa_scalar_exec.sv
// qtpa_scalar_exec: scalar/control execute stage behind instruction issue.
// Owns the 16x32 scalar register file, the hardware loop counter, the
// BRANCH/LOOP redirect and the HALT/YIELD control.
// Optional build macro QTPA_ILLEGAL_TRAP_EN: undefined opcodes set a sticky
// illegal_op flag and halt; without it they retire as NOPs.

package qtpa_scalar_exec_pkg;
  localparam int unsigned DATA_WIDTH  = 32;
  localparam int unsigned IMM_WIDTH   = 18;
  localparam int unsigned LC_WIDTH    = 18;
  localparam int unsigned INSTR_WIDTH = 32;
  localparam int unsigned OPC_WIDTH   = 6;
  localparam int unsigned RA_WIDTH    = 4;
  localparam int unsigned RF_DEPTH    = 16;

  localparam logic [OPC_WIDTH-1:0] OP_NOP       = 6'h00;
  localparam logic [OPC_WIDTH-1:0] OP_ADD_IMM   = 6'h01;
  localparam logic [OPC_WIDTH-1:0] OP_SUB_IMM   = 6'h02;
  localparam logic [OPC_WIDTH-1:0] OP_AND_IMM   = 6'h03;
  localparam logic [OPC_WIDTH-1:0] OP_OR_IMM    = 6'h04;
  localparam logic [OPC_WIDTH-1:0] OP_MOV_IMM   = 6'h05;
  localparam logic [OPC_WIDTH-1:0] OP_CMP_IMM   = 6'h06;
  localparam logic [OPC_WIDTH-1:0] OP_ADD_REG   = 6'h08;
  localparam logic [OPC_WIDTH-1:0] OP_SUB_REG   = 6'h09;
  localparam logic [OPC_WIDTH-1:0] OP_AND_REG   = 6'h0A;
  localparam logic [OPC_WIDTH-1:0] OP_OR_REG    = 6'h0B;
  localparam logic [OPC_WIDTH-1:0] OP_MOV_REG   = 6'h0C;
  localparam logic [OPC_WIDTH-1:0] OP_CMP_REG   = 6'h0D;
  localparam logic [OPC_WIDTH-1:0] OP_LCSET_IMM = 6'h10;
  localparam logic [OPC_WIDTH-1:0] OP_LCSET_REG = 6'h11;
  localparam logic [OPC_WIDTH-1:0] OP_LOOP      = 6'h12;
  localparam logic [OPC_WIDTH-1:0] OP_BRANCH    = 6'h13;
  localparam logic [OPC_WIDTH-1:0] OP_YIELD     = 6'h14;
  localparam logic [OPC_WIDTH-1:0] OP_HALT      = 6'h15;

  localparam logic [RA_WIDTH-1:0] REG_TILE  = 4'd13;
  localparam logic [RA_WIDTH-1:0] REG_SCALE = 4'd14;
  localparam logic [RA_WIDTH-1:0] REG_SR    = 4'd15;

  // ss2 occupies the top nibble of the imm18 field
  typedef struct packed {
    logic [OPC_WIDTH-1:0] opcode;
    logic [RA_WIDTH-1:0]  sd;
    logic [RA_WIDTH-1:0]  ss1;
    logic [IMM_WIDTH-1:0] imm;
  } instr_t;
endpackage

module qtpa_scalar_exec
  import qtpa_scalar_exec_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   instr_valid,
  output logic                   instr_ready,
  input  logic [INSTR_WIDTH-1:0] instr,
  input  logic                   iq_empty,
  input  logic                   dq_empty,
  input  logic                   stall_in,
  input  logic                   resume,
  output logic                   redirect_valid,
  output logic [IMM_WIDTH-1:0]   redirect_target,
  output logic                   yield_pulse,
  output logic                   halted,
  output logic                   illegal_op,
  output logic [DATA_WIDTH-1:0]  tile_size,
  output logic [DATA_WIDTH-1:0]  scale_factor,
  input  logic [RA_WIDTH-1:0]    dbg_raddr,
  output logic [DATA_WIDTH-1:0]  dbg_rdata
);

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_HALTED = 1'b1} state_e;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_MOV} alu_op_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] rf_q [RF_DEPTH];
  logic [DATA_WIDTH-1:0] rf_d [RF_DEPTH];
  logic [2:0]            flags_q, flags_d;   // {V, C, Z}
  logic                  sparse_q, sparse_d;
  logic [LC_WIDTH-1:0]   lc_q, lc_d;
  logic                  redir_q, redir_d;
  logic [IMM_WIDTH-1:0]  tgt_q, tgt_d;
  logic                  yield_q, yield_d;
`ifdef QTPA_ILLEGAL_TRAP_EN
  logic                  illegal_q, illegal_d;
  logic                  known_c;
`endif

  instr_t                ins_c;
  logic                  accept_c;
  logic [DATA_WIDTH-1:0] view_c [RF_DEPTH];
  logic [DATA_WIDTH-1:0] sr_c, ss1_val_c, ss2_val_c, opb_c, res_c;
  logic [DATA_WIDTH:0]   sum_c, diff_c;
  logic                  z_c, c_c, v_c;
  logic                  alu_en_c, wb_en_c, use_imm_c, zext_c;
  alu_op_e               alu_op_c;

  assign ins_c       = instr_t'(instr);
  assign instr_ready = !rst && (state_q == ST_RUN) && !redir_q;
  assign accept_c    = instr_valid && instr_ready;

  assign sr_c = {{(DATA_WIDTH-8){1'b0}}, stall_in, (lc_q != '0), sparse_q,
                 dq_empty, iq_empty, flags_q};

  // Architectural register view: S0 reads zero, S15 is the live status word
  always_comb begin
    view_c         = rf_q;
    view_c[0]      = '0;
    view_c[REG_SR] = sr_c;
  end

  assign ss1_val_c = view_c[ins_c.ss1];
  assign ss2_val_c = view_c[ins_c.imm[IMM_WIDTH-1 -: RA_WIDTH]];
  assign dbg_rdata = view_c[dbg_raddr];

  // Opcode decode into ALU controls
  always_comb begin
    alu_en_c  = 1'b0;
    wb_en_c   = 1'b0;
    use_imm_c = 1'b0;
    zext_c    = 1'b0;
    alu_op_c  = ALU_ADD;
`ifdef QTPA_ILLEGAL_TRAP_EN
    known_c   = 1'b1;
`endif
    case (ins_c.opcode)
      OP_ADD_IMM: begin alu_en_c = 1'b1; wb_en_c = 1'b1; use_imm_c = 1'b1; alu_op_c = ALU_ADD; end
      OP_SUB_IMM: begin alu_en_c = 1'b1; wb_en_c = 1'b1; use_imm_c = 1'b1; alu_op_c = ALU_SUB; end
      OP_AND_IMM: begin alu_en_c = 1'b1; wb_en_c = 1'b1; use_imm_c = 1'b1; zext_c = 1'b1; alu_op_c = ALU_AND; end
      OP_OR_IMM:  begin alu_en_c = 1'b1; wb_en_c = 1'b1; use_imm_c = 1'b1; zext_c = 1'b1; alu_op_c = ALU_OR; end
      OP_MOV_IMM: begin alu_en_c = 1'b1; wb_en_c = 1'b1; use_imm_c = 1'b1; alu_op_c = ALU_MOV; end
      OP_CMP_IMM: begin alu_en_c = 1'b1; use_imm_c = 1'b1; alu_op_c = ALU_SUB; end
      OP_ADD_REG: begin alu_en_c = 1'b1; wb_en_c = 1'b1; alu_op_c = ALU_ADD; end
      OP_SUB_REG: begin alu_en_c = 1'b1; wb_en_c = 1'b1; alu_op_c = ALU_SUB; end
      OP_AND_REG: begin alu_en_c = 1'b1; wb_en_c = 1'b1; alu_op_c = ALU_AND; end
      OP_OR_REG:  begin alu_en_c = 1'b1; wb_en_c = 1'b1; alu_op_c = ALU_OR; end
      OP_MOV_REG: begin alu_en_c = 1'b1; wb_en_c = 1'b1; alu_op_c = ALU_MOV; end
      OP_CMP_REG: begin alu_en_c = 1'b1; alu_op_c = ALU_SUB; end
      OP_NOP, OP_LCSET_IMM, OP_LCSET_REG, OP_LOOP,
      OP_BRANCH, OP_YIELD, OP_HALT: ;
      default: begin
`ifdef QTPA_ILLEGAL_TRAP_EN
        known_c = 1'b0;
`endif
      end
    endcase
  end

  assign opb_c = !use_imm_c ? ss2_val_c :
                 zext_c     ? DATA_WIDTH'(ins_c.imm) :
                 {{(DATA_WIDTH-IMM_WIDTH){ins_c.imm[IMM_WIDTH-1]}}, ins_c.imm};

  // ALU result and flags; MOV passes the immediate or ss1
  always_comb begin
    sum_c  = {1'b0, ss1_val_c} + {1'b0, opb_c};
    diff_c = {1'b0, ss1_val_c} - {1'b0, opb_c};
    res_c  = '0;
    c_c    = 1'b0;
    v_c    = 1'b0;
    case (alu_op_c)
      ALU_ADD: begin
        res_c = sum_c[DATA_WIDTH-1:0];
        c_c   = sum_c[DATA_WIDTH];
        v_c   = (ss1_val_c[DATA_WIDTH-1] == opb_c[DATA_WIDTH-1]) &&
                (res_c[DATA_WIDTH-1] != ss1_val_c[DATA_WIDTH-1]);
      end
      ALU_SUB: begin
        res_c = diff_c[DATA_WIDTH-1:0];
        c_c   = !diff_c[DATA_WIDTH];
        v_c   = (ss1_val_c[DATA_WIDTH-1] != opb_c[DATA_WIDTH-1]) &&
                (res_c[DATA_WIDTH-1] != ss1_val_c[DATA_WIDTH-1]);
      end
      ALU_AND: res_c = ss1_val_c & opb_c;
      ALU_OR:  res_c = ss1_val_c | opb_c;
      ALU_MOV: res_c = use_imm_c ? opb_c : ss1_val_c;
      default: res_c = '0;
    endcase
    z_c = (res_c == '0);
  end

  // Next-state: writeback, flags, loop counter, redirect and run/halt control
  always_comb begin
    state_d  = state_q;
    rf_d     = rf_q;
    flags_d  = flags_q;
    sparse_d = sparse_q;
    lc_d     = lc_q;
    redir_d  = 1'b0;
    tgt_d    = tgt_q;
    yield_d  = 1'b0;
`ifdef QTPA_ILLEGAL_TRAP_EN
    illegal_d = illegal_q;
`endif
    if ((state_q == ST_HALTED) && resume) begin
      state_d = ST_RUN;
    end
    if (accept_c) begin
      if (alu_en_c) begin
        if (wb_en_c && (ins_c.sd == REG_SR)) begin
          flags_d  = res_c[2:0];
          sparse_d = res_c[5];
        end else begin
          flags_d = {v_c, c_c, z_c};
          if (wb_en_c && (ins_c.sd != '0)) begin
            rf_d[ins_c.sd] = res_c;
          end
        end
      end
      case (ins_c.opcode)
        OP_LCSET_IMM: lc_d = LC_WIDTH'(ins_c.imm);
        OP_LCSET_REG: lc_d = ss1_val_c[LC_WIDTH-1:0];
        OP_LOOP: begin
          if (lc_q > LC_WIDTH'(1)) begin
            lc_d    = lc_q - LC_WIDTH'(1);
            redir_d = 1'b1;
            tgt_d   = ins_c.imm;
          end else begin
            lc_d = '0;
          end
        end
        OP_BRANCH: begin
          if (ss1_val_c == '0) begin
            redir_d = 1'b1;
            tgt_d   = ins_c.imm;
          end
        end
        OP_YIELD: yield_d = 1'b1;
        OP_HALT:  state_d = ST_HALTED;
        default: ;
      endcase
`ifdef QTPA_ILLEGAL_TRAP_EN
      if (!known_c) begin
        illegal_d = 1'b1;
        state_d   = ST_HALTED;
      end
`endif
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      rf_q     <= '{default: '0};
      flags_q  <= '0;
      sparse_q <= 1'b0;
      lc_q     <= '0;
      redir_q  <= 1'b0;
      tgt_q    <= '0;
      yield_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rf_q     <= rf_d;
      flags_q  <= flags_d;
      sparse_q <= sparse_d;
      lc_q     <= lc_d;
      redir_q  <= redir_d;
      tgt_q    <= tgt_d;
      yield_q  <= yield_d;
    end
  end

`ifdef QTPA_ILLEGAL_TRAP_EN
  // Sticky illegal-opcode flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) illegal_q <= 1'b0;
    else     illegal_q <= illegal_d;
  end
  assign illegal_op = illegal_q;
`else
  assign illegal_op = 1'b0;
`endif

  assign redirect_valid  = redir_q;
  assign redirect_target = tgt_q;
  assign yield_pulse     = yield_q;
  assign halted          = (state_q == ST_HALTED);
  assign tile_size       = rf_q[REG_TILE];
  assign scale_factor    = rf_q[REG_SCALE];

endmodule

// File: tb/tb_qtpa_scalar_exec.sv
// Self-checking bench for qtpa_scalar_exec: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_qtpa_scalar_exec;
  import qtpa_scalar_exec_pkg::*;

  logic        clk, rst, instr_valid, instr_ready;
  logic [31:0] instr;
  logic        iq_empty, dq_empty, stall_in, resume;
  logic        redirect_valid, yield_pulse, halted, illegal_op;
  logic [17:0] redirect_target;
  logic [31:0] tile_size, scale_factor, dbg_rdata;
  logic [3:0]  dbg_raddr;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 0;

  // Behavioural model state
  logic [31:0] m_s [16];
  logic [2:0]  m_flags;
  logic        m_sparse;
  int          m_lc;
  bit          m_halted, m_redir, m_yield, m_illegal;
  logic [17:0] m_tgt;

  logic [5:0] ops [19] = '{OP_NOP, OP_ADD_IMM, OP_SUB_IMM, OP_AND_IMM, OP_OR_IMM,
                           OP_MOV_IMM, OP_CMP_IMM, OP_ADD_REG, OP_SUB_REG, OP_AND_REG,
                           OP_OR_REG, OP_MOV_REG, OP_CMP_REG, OP_LCSET_IMM, OP_LCSET_REG,
                           OP_LOOP, OP_BRANCH, OP_YIELD, OP_HALT};

  qtpa_scalar_exec dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .iq_empty(iq_empty), .dq_empty(dq_empty), .stall_in(stall_in),
    .resume(resume), .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .yield_pulse(yield_pulse), .halted(halted), .illegal_op(illegal_op),
    .tile_size(tile_size), .scale_factor(scale_factor),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] sx(input logic [17:0] imm);
    return 32'($signed(imm));
  endfunction

  function automatic logic [31:0] m_rd(input logic [3:0] a);
    if (a == 4'd0) return 32'h0;
    if (a == 4'd15) return {24'h0, stall_in, (m_lc != 0), m_sparse, dq_empty, iq_empty, m_flags};
    return m_s[a];
  endfunction

  function automatic bit m_ready();
    return !rst && !m_halted && !m_redir;
  endfunction

  function automatic bit is_defined(input logic [5:0] op);
    foreach (ops[i]) if (ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  // Architectural effect of one clock edge
  task automatic model_step();
    bit acc, alu, wb, taken;
    logic [5:0] op;
    logic [3:0] sd, s1, s2;
    logic [17:0] imm;
    logic [31:0] a, b, res;
    logic [63:0] wide;
    longint sv;
    logic c, v;
    if (rst) begin
      foreach (m_s[i]) m_s[i] = 32'h0;
      m_flags = 0; m_sparse = 0; m_lc = 0; m_halted = 0; m_redir = 0;
      m_yield = 0; m_illegal = 0; m_tgt = 0;
      return;
    end
    acc = instr_valid && m_ready();
    m_redir = 0; m_yield = 0;
    if (m_halted && resume) m_halted = 0;
    if (!acc) return;
    {op, sd, s1, imm} = instr;
    s2 = imm[17:14];
    a = m_rd(s1); b = 0; res = 0; c = 0; v = 0; alu = 1; wb = 1; taken = 0;
    case (op)
      OP_ADD_IMM, OP_ADD_REG: begin
        b = (op == OP_ADD_IMM) ? sx(imm) : m_rd(s2);
        wide = 64'(a) + 64'(b);
        res = wide[31:0]; c = wide[32];
        sv = longint'($signed(a)) + longint'($signed(b));
        v = (sv != longint'($signed(res)));
      end
      OP_SUB_IMM, OP_SUB_REG, OP_CMP_IMM, OP_CMP_REG: begin
        b = (op == OP_SUB_IMM || op == OP_CMP_IMM) ? sx(imm) : m_rd(s2);
        res = a - b; c = (a >= b);
        sv = longint'($signed(a)) - longint'($signed(b));
        v = (sv != longint'($signed(res)));
        wb = (op == OP_SUB_IMM || op == OP_SUB_REG);
      end
      OP_AND_IMM: res = a & 32'(imm);
      OP_AND_REG: res = a & m_rd(s2);
      OP_OR_IMM:  res = a | 32'(imm);
      OP_OR_REG:  res = a | m_rd(s2);
      OP_MOV_IMM: res = sx(imm);
      OP_MOV_REG: res = a;
      default: alu = 0;
    endcase
    if (alu) begin
      if (wb && sd == 4'd15) begin
        m_flags = res[2:0]; m_sparse = res[5];
      end else begin
        m_flags = {v, c, (res == 0)};
        if (wb && sd != 4'd0) m_s[sd] = res;
      end
    end
    case (op)
      OP_LCSET_IMM: m_lc = int'(imm);
      OP_LCSET_REG: m_lc = int'(a[17:0]);
      OP_LOOP: if (m_lc > 1) begin m_lc = m_lc - 1; taken = 1; end else m_lc = 0;
      OP_BRANCH: taken = (a == 0);
      OP_YIELD: m_yield = 1;
      OP_HALT: m_halted = 1;
      default: ;
    endcase
    if (taken) begin m_redir = 1; m_tgt = imm; end
`ifdef QTPA_ILLEGAL_TRAP_EN
    if (!is_defined(op)) begin m_illegal = 1; m_halted = 1; end
`endif
  endtask

  always @(posedge clk) model_step();

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      #2;
      chk("instr_ready", 32'(instr_ready), 32'(m_ready()));
      chk("redirect_valid", 32'(redirect_valid), 32'(m_redir));
      if (m_redir) chk("redirect_target", 32'(redirect_target), 32'(m_tgt));
      chk("yield_pulse", 32'(yield_pulse), 32'(m_yield));
      chk("halted", 32'(halted), 32'(m_halted));
      chk("illegal_op", 32'(illegal_op), 32'(m_illegal));
      chk("tile_size", tile_size, m_s[13]);
      chk("scale_factor", scale_factor, m_s[14]);
      chk("dbg_rdata", dbg_rdata, m_rd(dbg_raddr));
    end
  end

  function automatic logic [31:0] enc(input logic [5:0] op, input logic [3:0] sd,
                                      input logic [3:0] s1, input logic [17:0] imm);
    return {op, sd, s1, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [3:0] sd,
                                        input logic [3:0] s1, input logic [3:0] s2);
    return {op, sd, s1, s2, 14'h0};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [5:0] op;
    logic [17:0] imm;
    if ($urandom_range(0, 7) == 0) op = 6'($urandom_range(0, 63));
    else op = ops[$urandom_range(0, 18)];
    if ($urandom_range(0, 1) == 0) imm = 18'($urandom_range(0, 7));
    else imm = 18'($urandom);
    if ($urandom_range(0, 3) == 0) imm[17:14] = 4'd0;
    return {op, 4'($urandom), 4'($urandom_range(0, 15)), imm};
  endfunction

  task automatic cyc(input logic v, input logic [31:0] ins,
                     input logic rs = 1'b0, input logic rm = 1'b0);
    @(negedge clk);
    rst = rs; resume = rm; instr_valid = v; instr = ins;
    @(posedge clk);
    #2;
  endtask

  task automatic peek(input logic [3:0] r, input string name, input logic [31:0] exp);
    dbg_raddr = r;
    #1;
    chk(name, dbg_rdata, exp);
  endtask

  initial begin
    clk = 0; rst = 1; instr_valid = 0; instr = 0; resume = 0;
    iq_empty = 0; dq_empty = 0; stall_in = 0; dbg_raddr = 0;
    repeat (2) @(posedge clk);
    chk_en = 1;
    cyc(0, 0, 1);
    cyc(0, 0);
    chk("reset_ready", 32'(instr_ready), 32'd1);
    chk("reset_halted", 32'(halted), 32'd0);
    peek(4'd15, "reset_sr", 32'h0);

    // Back-to-back dependent ADD
    cyc(1, enc(OP_MOV_IMM, 1, 0, 18'h3FFFF));
    cyc(1, enc_r(OP_ADD_REG, 2, 1, 1));
    cyc(0, 0);
    peek(4'd1, "mov_s1", 32'hFFFF_FFFF);
    peek(4'd2, "add_s2", 32'hFFFF_FFFE);
    peek(4'd15, "add_flags", 32'h0000_0002);

    // SUB borrow then CMP equal
    cyc(1, enc(OP_SUB_IMM, 3, 0, 18'd1));
    peek(4'd15, "sub_flags", 32'h0);
    cyc(1, enc(OP_CMP_IMM, 0, 3, 18'h3FFFF));
    peek(4'd15, "cmp_flags", 32'h0000_0003);
    peek(4'd3, "cmp_s3_kept", 32'hFFFF_FFFF);

    // S0 discard and SR write
    cyc(1, enc(OP_MOV_IMM, 0, 0, 18'd5));
    peek(4'd0, "s0_zero", 32'h0);
    cyc(1, enc(OP_MOV_IMM, 15, 0, 18'h27));
    peek(4'd15, "sr_write", 32'h0000_0027);
    iq_empty = 1;
    peek(4'd15, "sr_iq_live", 32'h0000_002F);
    iq_empty = 0;

    // Loop counter: two taken, third falls through
    cyc(1, enc(OP_LCSET_IMM, 0, 0, 18'd3));
    peek(4'd15, "sr_lc_nz", 32'h0000_0067);
    cyc(1, enc(OP_LOOP, 0, 0, 18'h40));
    chk("loop1_redir", 32'(redirect_valid), 32'd1);
    chk("loop1_tgt", 32'(redirect_target), 32'h40);
    chk("loop1_ready", 32'(instr_ready), 32'd0);
    cyc(1, enc(OP_LOOP, 0, 0, 18'h40));
    chk("loop1_pulse_end", 32'(redirect_valid), 32'd0);
    cyc(1, enc(OP_LOOP, 0, 0, 18'h40));
    chk("loop2_redir", 32'(redirect_valid), 32'd1);
    chk("loop2_ready", 32'(instr_ready), 32'd0);
    cyc(1, enc(OP_LOOP, 0, 0, 18'h40));
    cyc(1, enc(OP_LOOP, 0, 0, 18'h40));
    chk("loop3_not_taken", 32'(redirect_valid), 32'd0);
    peek(4'd15, "loop_lc_zero", 32'h0000_0027);

    // HALT with valid held, resume, then reset while halted
    cyc(1, enc(OP_HALT, 0, 0, 18'd0));
    chk("halt_set", 32'(halted), 32'd1);
    repeat (10) cyc(1, enc(OP_ADD_IMM, 4, 0, 18'd1));
    peek(4'd4, "halt_no_accept", 32'h0);
    cyc(1, enc(OP_ADD_IMM, 4, 0, 18'd1), 0, 1);
    chk("resume_ready", 32'(instr_ready), 32'd1);
    cyc(1, enc(OP_ADD_IMM, 4, 0, 18'd1));
    peek(4'd4, "resume_accept", 32'h1);
    cyc(1, enc(OP_HALT, 0, 0, 18'd0));
    cyc(0, 0, 1);
    rst = 0;
    #1;
    chk("rst_halt_clear", 32'(halted), 32'd0);
    chk("rst_ready", 32'(instr_ready), 32'd1);
    peek(4'd1, "rst_s1", 32'h0);

    // Vector-range opcode
    cyc(1, {6'h3F, 26'h0});
`ifdef QTPA_ILLEGAL_TRAP_EN
    chk("trap_illegal", 32'(illegal_op), 32'd1);
    chk("trap_halted", 32'(halted), 32'd1);
    cyc(0, 0, 0, 1);
    chk("trap_sticky", 32'(illegal_op), 32'd1);
`else
    chk("nop_illegal", 32'(illegal_op), 32'd0);
    chk("nop_ready", 32'(instr_ready), 32'd1);
`endif
    cyc(1, enc(OP_MOV_IMM, 5, 0, 18'd7));
    peek(4'd5, "after_undef", 32'h7);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 299) == 0);
      resume = ($urandom_range(0, 5) == 0);
      iq_empty = 1'($urandom);
      dq_empty = 1'($urandom);
      stall_in = 1'($urandom);
      dbg_raddr = 4'($urandom);
      instr_valid = ($urandom_range(0, 3) != 0);
      instr = rand_instr();
      @(posedge clk);
    end

    @(posedge clk);
    chk_en = 0;
    #20;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
